// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: client (fetch, load/store) and 8-bit RAM/IO bus signals of mem_ctrl.
// Latency: none, wires only.
// Backpressure: clients hold req until their done pulse; the global rdy lives outside.
// Ports: master = clients + RAM side (drive reqs and mem_din); slave = controller.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;

    logic              ls_req;
    logic              ls_wr;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and load/store requests into byte cycles on an 8-bit RAM/IO bus.
// Latency: accept edge to done is N+1 cycles for reads, N for writes (N = 1/2/4 bytes).
// Backpressure: clients hold req until done; rdy=0 freezes all state and gates mem_wr.
// Ports: clk; rst (async, active-low); rdy (global ready); bus (mem_ctrl_if.slave).
module mem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int IF_BYTES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [2:0] IF_N = 3'(IF_BYTES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_n;
    logic [2:0]        r_cnt;
    logic              r_is_ls;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_if_data;
    logic [31:0]       r_ls_rdata;

    logic [2:0]        w_ls_n;
    logic [1:0]        w_byte_idx;
    logic [31:0]       w_assembled;
    logic [7:0]        w_wbyte;
    logic              w_addr_phase;

    always_comb begin
        case (bus.ls_size)
            2'd0:    w_ls_n = 3'd1;
            2'd1:    w_ls_n = 3'd2;
            default: w_ls_n = 3'd4;
        endcase
    end

    // In RD the byte arriving on mem_din belongs to the address driven one
    // cycle earlier, i.e. byte index r_cnt-1.
    assign w_byte_idx   = r_cnt[1:0] - 2'd1;
    assign w_assembled  = r_buf | ({24'd0, bus.mem_din} << {w_byte_idx, 3'b000});
    assign w_wbyte      = 8'(r_wdata >> {r_cnt[1:0], 3'b000});
    assign w_addr_phase = (r_cnt < r_n);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; load/store wins over fetch when both are pending.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.ls_req) begin
                    w_state_nxt = bus.ls_wr ? WR : RD;
                end else if (bus.if_req) begin
                    w_state_nxt = RD;
                end
            end
            RD:      if (r_cnt == r_n) w_state_nxt = ACK;
            WR:      if (r_cnt == r_n - 3'd1) w_state_nxt = ACK;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, byte counter and read assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base     <= '0;
            r_n        <= 3'd0;
            r_cnt      <= 3'd0;
            r_is_ls    <= 1'b0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else if (rdy) begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 3'd0;
                    r_buf <= 32'd0;
                    if (bus.ls_req) begin
                        r_base  <= bus.ls_addr;
                        r_n     <= w_ls_n;
                        r_is_ls <= 1'b1;
                        r_wdata <= bus.ls_wdata;
                    end else if (bus.if_req) begin
                        r_base  <= bus.if_addr;
                        r_n     <= IF_N;
                        r_is_ls <= 1'b0;
                    end
                end
                RD: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd0) begin
                        r_buf <= w_assembled;
                    end
                    // Result registers only change on completion so the
                    // previous value stays visible for the whole read.
                    if (r_cnt == r_n) begin
                        if (r_is_ls) begin
                            r_ls_rdata <= w_assembled;
                        end else begin
                            r_if_data <= w_assembled;
                        end
                    end
                end
                WR: begin
                    r_cnt <= r_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Output logic; bus outputs decode from held state so a freeze keeps them.
    always_comb begin
        bus.mem_a    = '0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = 8'd0;
        bus.if_done  = 1'b0;
        bus.ls_done  = 1'b0;
        case (r_state)
            RD: begin
                if (w_addr_phase) begin
                    bus.mem_a = r_base + ADDR_W'(r_cnt);
                end
            end
            WR: begin
                bus.mem_a    = r_base + ADDR_W'(r_cnt);
                bus.mem_wr   = rdy;
                bus.mem_dout = w_wbyte;
            end
            ACK: begin
                bus.if_done = !r_is_ls;
                bus.ls_done = r_is_ls;
            end
            default: ;
        endcase
    end

    assign bus.if_data  = r_if_data;
    assign bus.ls_rdata = r_ls_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a transaction-level model.
// Latency: n/a.
// Backpressure: bench requesters hold req until done; rdy toggled randomly.
module tb_mem_ctrl;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    mem_ctrl_if #(.ADDR_W(AW)) bus ();

    mem_ctrl #(.ADDR_W(AW), .IF_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endfunction

    // ---------------- RAM on the bus (frozen by the global rdy like the rest of the system)
    logic [7:0] ram  [logic [31:0]];
    logic [7:0] mmem [logic [31:0]];

    function automatic logic [7:0] dflt(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction
    function automatic logic [7:0] ram_rd(logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return dflt(a);
    endfunction
    function automatic logic [7:0] mm_rd(logic [31:0] a);
        if (mmem.exists(a)) return mmem[a];
        return dflt(a);
    endfunction
    task automatic preload(logic [31:0] a, logic [7:0] d);
        ram[a]  = d;
        mmem[a] = d;
    endtask

    always @(posedge clk) begin
        if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
            bus.mem_din <= ram_rd(bus.mem_a);
        end
    end

    // ---------------- transaction-level model
    // m_t numbers the active cycles of a transaction from 1; a read of N bytes
    // spans N+2 cycles (N addresses, one trailing, one done), a write N+1.
    bit          m_act = 1'b0;
    int          m_t = 0;
    int          m_n = 0;
    bit          m_ls = 1'b0;
    bit          m_wr = 1'b0;
    logic [31:0] m_base = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] e_if_data = 32'd0;
    logic [31:0] e_ls_rdata = 32'd0;

    function automatic int m_last();
        return m_wr ? m_n + 1 : m_n + 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act      = 1'b0;
            m_t        = 0;
            e_if_data  = 32'd0;
            e_ls_rdata = 32'd0;
        end else if (rdy) begin
            if (m_act) begin
                if (m_wr && m_t <= m_n) mmem[m_base + 32'(m_t - 1)] = m_wdata[8*(m_t-1) +: 8];
                if (m_t == m_last()) begin
                    m_act = 1'b0;
                end else begin
                    m_t++;
                    if (m_t == m_last() && !m_wr) begin
                        if (m_ls) e_ls_rdata = m_rdata;
                        else      e_if_data  = m_rdata;
                    end
                end
            end else if (bus.ls_req || bus.if_req) begin
                m_act   = 1'b1;
                m_t     = 1;
                m_ls    = bus.ls_req;
                m_wr    = bus.ls_req && bus.ls_wr;
                m_base  = m_ls ? bus.ls_addr : bus.if_addr;
                m_n     = !m_ls ? 4 : (bus.ls_size == 2'd0 ? 1 : (bus.ls_size == 2'd1 ? 2 : 4));
                m_wdata = bus.ls_wdata;
                m_rdata = 32'd0;
                if (!m_wr) for (int k = 0; k < m_n; k++) m_rdata[8*k +: 8] = mm_rd(m_base + 32'(k));
            end
        end
    end

    // ---------------- per-cycle compare
    always @(negedge clk) begin
        #1;
        begin : cmp
            logic [31:0] ea;
            logic [7:0]  ed;
            logic        ew, eid, eld;
            ea = 32'd0; ed = 8'd0; ew = 1'b0; eid = 1'b0; eld = 1'b0;
            if (m_act) begin
                if (m_t <= m_n) begin
                    ea = m_base + 32'(m_t - 1);
                    if (m_wr) begin
                        ew = rdy;
                        ed = m_wdata[8*(m_t-1) +: 8];
                    end
                end
                if (m_t == m_last()) begin
                    if (m_ls) eld = 1'b1;
                    else      eid = 1'b1;
                end
            end
            chk("mem_a", bus.mem_a, ea);
            chk("mem_wr", 32'(bus.mem_wr), 32'(ew));
            chk("mem_dout", 32'(bus.mem_dout), 32'(ed));
            chk("if_done", 32'(bus.if_done), 32'(eid));
            chk("ls_done", 32'(bus.ls_done), 32'(eld));
            chk("if_data", bus.if_data, e_if_data);
            chk("ls_rdata", bus.ls_rdata, e_ls_rdata);
        end
    end

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
        return 32'h1000 + 32'($urandom_range(0, 31));
    endfunction

    // ---------------- stimulus
    initial begin
        bit seen_ls, seen_if;
        int overlap, ls_wait, if_wait, stray;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 2'd0;
        bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;

        // reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_ls_done", 32'(bus.ls_done), 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
        rst = 1'b1;

        // word fetch at 0x100
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) chk("fetch_addr", bus.mem_a, 32'h100 + 32'(c - 1));
            if (c == 5) chk("fetch_early_done", 32'(bus.if_done), 32'd0);
        end
        chk("fetch_done", 32'(bus.if_done), 32'd1);
        chk("fetch_data", bus.if_data, 32'h0010_0513);
        chk("model_fetch", e_if_data, 32'h0010_0513);
        bus.if_req = 1'b0;

        // half store across 0x1FFFE/0x1FFFF
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'd1;
        bus.ls_addr = 32'h1FFFE; bus.ls_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk("hs_a0", bus.mem_a, 32'h1FFFE); chk("hs_wr0", 32'(bus.mem_wr), 32'd1);
        chk("hs_d0", 32'(bus.mem_dout), 32'hDD);
        @(negedge clk);
        chk("hs_a1", bus.mem_a, 32'h1FFFF); chk("hs_d1", 32'(bus.mem_dout), 32'hCC);
        @(negedge clk);
        chk("hs_done", 32'(bus.ls_done), 32'd1); chk("hs_wr_off", 32'(bus.mem_wr), 32'd0);
        chk("hs_ram0", 32'(ram_rd(32'h1FFFE)), 32'hDD);
        chk("hs_ram1", 32'(ram_rd(32'h1FFFF)), 32'hCC);
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0;

        // contention: byte load at IO address versus fetch
        @(negedge clk);
        preload(32'h30000, 8'h41);
        bus.ls_req = 1'b1; bus.ls_size = 2'd0; bus.ls_addr = 32'h30000;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        seen_ls = 1'b0; seen_if = 1'b0; overlap = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.ls_done && bus.if_done) overlap++;
            if (bus.ls_done && !seen_ls) begin
                seen_ls = 1'b1;
                chk("cont_ls_rdata", bus.ls_rdata, 32'h0000_0041);
                chk("model_ls", e_ls_rdata, 32'h0000_0041);
                chk("cont_ls_cycle", 32'(c), 32'd3);
                bus.ls_req = 1'b0;
            end
            if (bus.if_done) begin
                seen_if = 1'b1;
                chk("cont_if_after_ls", 32'(seen_ls), 32'd1);
                chk("cont_if_cycle", 32'(c), 32'd10);
                chk("cont_if_data", bus.if_data, 32'h0010_0513);
                bus.if_req = 1'b0;
                break;
            end
        end
        chk("cont_if_seen", 32'(seen_if), 32'd1);
        chk("cont_overlap", 32'(overlap), 32'd0);
        bus.ls_req = 1'b0; bus.if_req = 1'b0;

        // rdy low for 3 cycles during a word fetch
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                chk("stall_addr", bus.mem_a, 32'h101);
                chk("stall_wr", 32'(bus.mem_wr), 32'd0);
            end
            if (c == 6) chk("stall_not_early", 32'(bus.if_done), 32'd0);
            if (c == 2) rdy = 1'b0;
            if (c == 5) rdy = 1'b1;
        end
        chk("stall_done", 32'(bus.if_done), 32'd1);
        chk("stall_data", bus.if_data, 32'h0010_0513);
        bus.if_req = 1'b0;

        // reset during a word store after its first byte
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'd2;
        bus.ls_addr = 32'h400; bus.ls_wdata = 32'h11223344;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_mem_a", bus.mem_a, 32'd0);
        chk("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("abort_ls_done", 32'(bus.ls_done), 32'd0);
        chk("abort_ls_rdata", bus.ls_rdata, 32'd0);
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("abort_byte0", 32'(ram_rd(32'h400)), 32'h44);
        chk("abort_byte1", 32'(ram_rd(32'h401)), 32'(dflt(32'h401)));
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ls_done) stray++;
        end
        chk("abort_no_done", 32'(stray), 32'd0);
        bus.ls_req = 1'b1; bus.ls_size = 2'd2; bus.ls_addr = 32'h400;
        seen_ls = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.ls_done) begin seen_ls = 1'b1; break; end
        end
        chk("after_abort_done", 32'(seen_ls), 32'd1);
        chk("after_abort_data", bus.ls_rdata,
            {dflt(32'h403), dflt(32'h402), dflt(32'h401), 8'h44});
        bus.ls_req = 1'b0;

        // randomized traffic
        ls_wait = 0; if_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rdy = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 499) != 0);
            if (bus.ls_req) begin
                if (bus.ls_done) begin
                    bus.ls_req = 1'b0; ls_wait = 0;
                end else if (++ls_wait > 300) begin
                    chk("ls_timeout", 32'(ls_wait), 32'd0);
                    bus.ls_req = 1'b0; ls_wait = 0;
                end
            end else if (!bus.ls_done && $urandom_range(0, 3) == 0) begin
                bus.ls_req   = 1'b1;
                bus.ls_wr    = 1'($urandom_range(0, 1));
                bus.ls_size  = 2'($urandom_range(0, 3));
                bus.ls_addr  = rand_addr();
                bus.ls_wdata = $urandom;
            end
            if (bus.if_req) begin
                if (bus.if_done) begin
                    bus.if_req = 1'b0; if_wait = 0;
                end else if (++if_wait > 300) begin
                    chk("if_timeout", 32'(if_wait), 32'd0);
                    bus.if_req = 1'b0; if_wait = 0;
                end
            end else if (!bus.if_done && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = rand_addr();
            end
        end
        rst = 1'b1; rdy = 1'b1;
        bus.ls_req = 1'b0; bus.if_req = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
